// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (a, b, cin, sub)
//   out_valid/out_ready - result handshake (sum, cout, ovf)
//   cout is the no-borrow flag when sub=1; ovf is signed overflow.

module chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    // one extra bit so the counter can step past the last slice without wrapping
    localparam int CW  = $clog2(NCH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry_q;
    logic             ovf_q;
    logic [CW-1:0]    idx_q;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   part;
    logic             last;
    logic             accept;

    // ---------------- slice select and partial add ----------------
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        sum_nxt = sum_q;
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
        part = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < NCH; i++) begin
            if (idx_q == CW'(i)) begin
                sum_nxt[i*CHUNK +: CHUNK] = part[CHUNK-1:0];
            end
        end
    end

    assign last = (idx_q == CW'(NCH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && (state == IDLE);
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q <= a;
                        // subtraction as a + ~b + ~cin
                        b_q     <= sub ? ~b : b;
                        carry_q <= cin ^ sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_nxt;
                    carry_q <= part[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        // carry into MSB = a^b^s at MSB; xor with carry out
                        ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1]
                               ^ part[CHUNK-1] ^ part[CHUNK];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// tb_chunk_adder: directed table and sequences on CHUNK=2, plus
// randomized regression on CHUNK=1,2,4,8 against an arithmetic model.

module tb_chunk_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic mc, input logic ms,
                                  output logic [7:0] s, output logic co,
                                  output logic ov);
        int r;
        int sr;
        int sa;
        int sb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (!ms) begin
            r  = int'(ma) + int'(mb) + int'(mc);
            sr = sa + sb + int'(mc);
            co = (r > 255);
        end else begin
            r  = int'(ma) - int'(mb) - int'(mc);
            sr = sa - sb - int'(mc);
            co = (r >= 0);
        end
        s  = 8'(r);
        ov = (sr > 127) || (sr < -128);
    endfunction

    // Accept one operation on the main DUT and wait for out_valid.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic vs, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check("wait_in_ready", 0, 1);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [8];

    // ---------------- directed tests ----------------
    initial begin
        int lat;
        int t;
        logic seen;

        vecs[0] = '{8'd3,   8'd5,   1'b0, 1'b0, 8'd8,   1'b0, 1'b0};
        vecs[1] = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[2] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
        vecs[3] = '{8'd5,   8'd7,   1'b0, 1'b1, 8'd254, 1'b0, 1'b0};
        vecs[4] = '{8'd7,   8'd5,   1'b1, 1'b1, 8'd1,   1'b1, 1'b0};
        vecs[5] = '{8'd0,   8'd0,   1'b1, 1'b1, 8'd255, 1'b0, 1'b0};
        vecs[6] = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1};
        vecs[7] = '{8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_lat", i), lat, 4);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].s);
            check($sformatf("vec%0d_cout", i), cout, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
            release_op();
        end

        // backpressure: 100+50 = 150 overflows signed range
        run_op(8'd100, 8'd50, 1'b0, 1'b0, lat);
        check("bp_lat", lat, 4);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            check("bp_sum", sum, 150);
            check("bp_cout", cout, 0);
            check("bp_ovf", ovf, 1);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        // offer a new op on the release edge: must not be accepted there
        a = 8'd1; b = 8'd1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("bp_next_lat", lat, 4);
        check("bp_next_sum", sum, 2);
        release_op();

        // reset during the second RUN cycle
        a = 8'd3; b = 8'd5; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_valid", seen, 0);

        t = 0;
        while (done_cnt < 4 && t < 60000) begin
            @(posedge clk); t++;
        end
        if (done_cnt < 4) check("regress_timeout", done_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    // ---------------- randomized regression per CHUNK ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        localparam int CH = 1 << gi;

        logic       r_rst;
        logic       r_iv;
        logic       r_ir;
        logic [7:0] r_a;
        logic [7:0] r_b;
        logic       r_c;
        logic       r_s;
        logic       r_ov;
        logic       r_or;
        logic [7:0] r_sum;
        logic       r_cout;
        logic       r_ovf;

        chunk_adder #(.WIDTH(8), .CHUNK(CH)) u_dut (
            .clk      (clk),
            .rst      (r_rst),
            .in_valid (r_iv),
            .in_ready (r_ir),
            .a        (r_a),
            .b        (r_b),
            .cin      (r_c),
            .sub      (r_s),
            .out_valid(r_ov),
            .out_ready(r_or),
            .sum      (r_sum),
            .cout     (r_cout),
            .ovf      (r_ovf)
        );

        initial begin
            logic [7:0] ta;
            logic [7:0] tb2;
            logic       tc;
            logic       ts;
            logic [7:0] es;
            logic       eco;
            logic       eov;
            logic       stable;
            logic       rd;
            int         lat;
            int         t;
            int         g;

            r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b0;
            r_a = '0; r_b = '0; r_c = 1'b0; r_s = 1'b0;
            repeat (2) @(posedge clk);
            #1 r_rst = 1'b0;

            for (int n = 0; n < 300; n++) begin
                ta  = 8'($urandom);
                tb2 = 8'($urandom);
                tc  = 1'($urandom);
                ts  = 1'($urandom);
                model(ta, tb2, tc, ts, es, eco, eov);
                t = 0;
                while (!r_ir && t < 20) begin
                    @(posedge clk); #1; t++;
                end
                r_a = ta; r_b = tb2; r_c = tc; r_s = ts; r_iv = 1'b1;
                @(posedge clk); #1;
                r_iv = 1'b0;
                r_a = 8'($urandom); r_b = 8'($urandom);
                r_c = 1'($urandom); r_s = 1'($urandom);
                lat = 0;
                while (!r_ov && lat < 40) begin
                    @(posedge clk); #1; lat++;
                end
                check($sformatf("ch%0d_lat", CH), lat, 8 / CH);
                check($sformatf("ch%0d_sum a=%0d b=%0d c=%0d s=%0d",
                                CH, ta, tb2, tc, ts), r_sum, es);
                check($sformatf("ch%0d_cout a=%0d b=%0d c=%0d s=%0d",
                                CH, ta, tb2, tc, ts), r_cout, eco);
                check($sformatf("ch%0d_ovf a=%0d b=%0d c=%0d s=%0d",
                                CH, ta, tb2, tc, ts), r_ovf, eov);
                stable = 1'b1;
                g = 0;
                do begin
                    if (r_sum !== es || r_cout !== eco || r_ovf !== eov ||
                        r_ov !== 1'b1)
                        stable = 1'b0;
                    rd = 1'($urandom);
                    r_or = rd;
                    r_a = 8'($urandom); r_b = 8'($urandom);
                    @(posedge clk); #1;
                    g++;
                end while (!rd && g < 10);
                if (!rd) begin
                    r_or = 1'b1;
                    @(posedge clk); #1;
                end
                r_or = 1'b0;
                check($sformatf("ch%0d_hold", CH), stable, 1);
                check($sformatf("ch%0d_idle", CH), r_ir, 1);
            end
            done_cnt++;
        end
    end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2, meaning bits added per clock cycle; legal only if WIDTH % CHUNK == 0 and CHUNK <= WIDTH.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  operands presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have ports a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-008 The block SHALL have port cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have ports sum  output  WIDTH, cout  output  1, ovf  output  1  result, carry-out (no-borrow flag when sub=1), signed overflow.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-015 Accept SHALL occur on a rising edge with in_valid & in_ready; a, b, cin, sub are latched, chunk index cleared, state -> RUN.
REQ-016 Input changes after accept SHALL have no effect on the in-flight operation.
REQ-017 Operand latched as B SHALL be b when sub=0, ~b when sub=1; initial carry SHALL be cin when sub=0, ~cin when sub=1.
REQ-018 In RUN, each cycle SHALL add one CHUNK-bit slice of A and B plus the carry register, LSB slice first, writing the slice into sum and updating the carry register.
REQ-019 After NCH = WIDTH/CHUNK RUN cycles, state SHALL go to DONE; out_valid rises exactly NCH cycles after the accepting edge.
REQ-020 In DONE: cout = final carry; ovf = carry into MSB XOR carry out of MSB.
REQ-021 sum, cout, ovf SHALL hold stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
REQ-022 DONE with out_ready=1 SHALL go to IDLE on that edge; no new operand is accepted on the same edge (throughput one op per NCH+2 cycles minimum).
REQ-023 sum/cout/ovf values outside DONE are don't-care for consumers but SHALL NOT be X after reset.
REQ-024 CHUNK == WIDTH SHALL give a single RUN cycle (latency 1); CHUNK == 1 SHALL give bit-serial operation (latency WIDTH).
REQ-025 Chunk counter SHALL be sized ceil(log2(NCH))+1 bits minimum, with no wrap before DONE.

Reset
REQ-026 On a rising edge with rst=1, state SHALL become IDLE; sum, cout, ovf, carry register and chunk counter SHALL become 0; out_valid SHALL be 0 from that edge.
REQ-027 rst SHALL take priority over accept, RUN progression and DONE handshake on the same edge; an in-flight operation is discarded with no output.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=8, CHUNK=2, NCH=4)
REQ-029 Accept a=3, b=5, cin=0, sub=0 -> out_valid rises 4 cycles later, sum=8, cout=0, ovf=0.
REQ-030 a=255, b=1, cin=0, sub=0 -> sum=0, cout=1, ovf=0; a=127, b=1 -> sum=128, cout=0, ovf=1.
REQ-031 Subtract a=5, b=7, cin=0, sub=1 -> sum=254, cout=0 (borrow), ovf=0; a=7, b=5, cin=1, sub=1 -> sum=1, cout=1.
REQ-032 Hold out_ready=0 for 3 cycles in DONE while changing a/b -> sum/cout/ovf unchanged, in_ready=0; release -> IDLE next edge, in_ready=1.
REQ-033 Assert rst for 1 cycle during 2nd RUN cycle -> out_valid never rises for that operation, sum=0, in_ready=1 after release.
REQ-034 Nested-loop sweep of all a, b in 0..255, cin/sub in {0,1}, with random out_ready -> every result matches a+b+cin or a-b-cin mod 256 with correct cout/ovf; repeat at CHUNK=1, 4, 8.
